// File: rtl/load_mapping_unit_if.sv
// Handshake and data bundle between the load/store read port and the load mapping unit.
// The slave modport is the unit's view; master is the producer/consumer side.
interface load_mapping_unit_if #(
  parameter int MEM_W = 32
);
  localparam int LANES = MEM_W / 8;

  logic                  start_i;
  logic [1:0]            sew_i;
  logic                  sext_i;
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [MEM_W-1:0]      in_data_i;
  logic                  in_last_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [LANES*32-1:0]   out_data_o;
  logic [LANES-1:0]      out_lane_en_o;
  logic                  out_last_o;
  logic                  cfg_err_o;

  modport slave (
    input  start_i, sew_i, sext_i, in_valid_i, in_data_i, in_last_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_lane_en_o, out_last_o, cfg_err_o
  );

  modport master (
    output start_i, sew_i, sext_i, in_valid_i, in_data_i, in_last_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_lane_en_o, out_last_o, cfg_err_o
  );
endinterface

// File: rtl/load_mapping_unit.sv
// Unpacks SEW-wide elements from memory beats, extends each into a 32-bit lane and
// emits one arithmetic word per filled lane set (or transfer end) through a register stage.
module load_mapping_unit #(
  parameter int MEM_W = 32
) (
  input logic               clk_i,
  input logic               n_rst_i,
  load_mapping_unit_if.slave bus
);
  localparam int LANES = MEM_W / 8;
  localparam int OW    = LANES * 32;

  typedef enum logic {IDLE, ACCUM} state_e;

  state_e           state_q, state_d;
  logic [1:0]       sew_q, sew_d;
  logic             sext_q, sext_d;
  logic [1:0]       beat_cnt_q, beat_cnt_d;
  logic [OW-1:0]    acc_q, acc_d;
  logic [LANES-1:0] mask_q, mask_d;
  logic [OW-1:0]    out_data_q, out_data_d;
  logic [LANES-1:0] out_en_q, out_en_d;
  logic             out_last_q, out_last_d;
  logic             out_valid_q, out_valid_d;
  logic             cfg_err_q, cfg_err_d;

  logic [OW-1:0]    beat_lanes;
  logic [LANES-1:0] beat_mask;
  logic [1:0]       last_cnt;
  logic             in_ready;
  logic             accept;
  logic             complete;
  logic             start_ok;

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] sew,
                                         input logic sext);
    case (sew)
      2'd0:    return {{24{sext & raw[7]}}, raw[7:0]};
      2'd1:    return {{16{sext & raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    beat_lanes = '0;
    beat_mask  = '0;
    case (sew_q)
      2'd0: begin
        for (int j = 0; j < LANES; j++) begin
          beat_lanes[32*j +: 32] = extend({24'd0, bus.in_data_i[8*j +: 8]}, 2'd0, sext_q);
          beat_mask[j]           = 1'b1;
        end
      end
      2'd1: begin
        for (int j = 0; j < LANES/2; j++) begin
          beat_lanes[32*(int'(beat_cnt_q[0])*(LANES/2) + j) +: 32] =
            extend({16'd0, bus.in_data_i[16*j +: 16]}, 2'd1, sext_q);
          beat_mask[int'(beat_cnt_q[0])*(LANES/2) + j] = 1'b1;
        end
      end
      default: begin
        for (int j = 0; j < LANES/4; j++) begin
          beat_lanes[32*(int'(beat_cnt_q)*(LANES/4) + j) +: 32] = bus.in_data_i[32*j +: 32];
          beat_mask[int'(beat_cnt_q)*(LANES/4) + j]              = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    case (sew_q)
      2'd0:    last_cnt = 2'd0;
      2'd1:    last_cnt = 2'd1;
      default: last_cnt = 2'd3;
    endcase
  end

  assign start_ok = bus.start_i & (bus.sew_i != 2'd3);
  assign accept   = bus.in_valid_i & in_ready;
  assign complete = (beat_cnt_q == last_cnt) | bus.in_last_i;

  // FSM: state register
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (!n_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = ACCUM;
      ACCUM:   if (accept && complete && bus.in_last_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs; the ready path never looks at in_valid_i or in_last_i
  always_comb begin
    in_ready = (state_q == ACCUM) & (~out_valid_q | bus.out_ready_i);
  end

  always_comb begin
    sew_d       = sew_q;
    sext_d      = sext_q;
    beat_cnt_d  = beat_cnt_q;
    acc_d       = acc_q;
    mask_d      = mask_q;
    out_data_d  = out_data_q;
    out_en_d    = out_en_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    cfg_err_d   = 1'b0;

    if (state_q == IDLE && bus.start_i) begin
      if (bus.sew_i == 2'd3) begin
        cfg_err_d = 1'b1;
      end else begin
        sew_d      = bus.sew_i;
        sext_d     = bus.sext_i;
        beat_cnt_d = '0;
        acc_d      = '0;
        mask_d     = '0;
      end
    end

    if (out_valid_q && bus.out_ready_i) out_valid_d = 1'b0;

    // A completing beat reloads the output stage even while the old word drains.
    if (accept) begin
      if (complete) begin
        out_data_d  = acc_q | beat_lanes;
        out_en_d    = mask_q | beat_mask;
        out_last_d  = bus.in_last_i;
        out_valid_d = 1'b1;
        acc_d       = '0;
        mask_d      = '0;
        beat_cnt_d  = '0;
      end else begin
        acc_d      = acc_q | beat_lanes;
        mask_d     = mask_q | beat_mask;
        beat_cnt_d = beat_cnt_q + 2'd1;
      end
    end
  end

  // NOTE: the accumulator is reset too, so a reset mid-transfer cannot leak partial data.
  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      sew_q       <= '0;
      sext_q      <= 1'b0;
      beat_cnt_q  <= '0;
      acc_q       <= '0;
      mask_q      <= '0;
      out_data_q  <= '0;
      out_en_q    <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      sew_q       <= sew_d;
      sext_q      <= sext_d;
      beat_cnt_q  <= beat_cnt_d;
      acc_q       <= acc_d;
      mask_q      <= mask_d;
      out_data_q  <= out_data_d;
      out_en_q    <= out_en_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign bus.in_ready_o    = in_ready;
  assign bus.out_valid_o   = out_valid_q;
  assign bus.out_data_o    = out_data_q;
  assign bus.out_lane_en_o = out_en_q;
  assign bus.out_last_o    = out_last_q;
  assign bus.cfg_err_o     = cfg_err_q;
endmodule

// File: tb/tb_load_mapping_unit.sv
// Directed and randomized bench for load_mapping_unit; expected words come from an
// element-stream model (global element n lands in word n/LANES, lane n%LANES).
module tb_load_mapping_unit;
  localparam int MEM_W = 32;
  localparam int LANES = MEM_W / 8;
  localparam int OW    = LANES * 32;

  typedef struct packed {
    logic [OW-1:0]    data;
    logic [LANES-1:0] en;
    logic             last;
  } word_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  load_mapping_unit_if #(.MEM_W(MEM_W)) bus ();
  load_mapping_unit #(.MEM_W(MEM_W)) dut (.clk_i(clk), .n_rst_i(n_rst), .bus(bus));

  word_t      exp_q[$];
  word_t      cur_w;
  int         cur_n;
  bit         m_active;
  logic [1:0] m_sew;
  logic       m_sext;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         rand_mode = 0;
  bit         in_hs = 0;
  bit         prev_stall = 0;
  word_t      prev_out;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_beat(input logic [31:0] d, input logic last);
    int         w;
    int         e;
    int         lane;
    logic [31:0] m;
    logic [31:0] el;
    w = 8 << m_sew;
    e = 32 / w;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    for (int j = 0; j < e; j++) begin
      el = (d >> (j * w)) & m;
      if (m_sext && el[w-1]) el = el | ~m;
      lane = cur_n % LANES;
      cur_w.data[32*lane +: 32] = el;
      cur_w.en[lane] = 1'b1;
      cur_n++;
    end
    if (cur_n == LANES || last) begin
      cur_w.last = last;
      exp_q.push_back(cur_w);
      cur_w = '0;
      cur_n = 0;
    end
    if (last) m_active = 0;
  endtask

  task automatic monitor();
    word_t o;
    word_t e;
    if (!n_rst) begin
      exp_q.delete();
      cur_w = '0;
      cur_n = 0;
      m_active = 0;
      prev_stall = 0;
      in_hs = 0;
      return;
    end
    o = {bus.out_data_o, bus.out_lane_en_o, bus.out_last_o};
    if (prev_stall) begin
      check("stall_valid", bus.out_valid_o, 1);
      check("stall_hold", o, prev_out);
    end
    if (bus.out_valid_o && !bus.out_ready_i) check("stall_in_ready", bus.in_ready_o, 0);
    if (bus.out_valid_o && bus.out_ready_i) begin
      if (exp_q.size() == 0) begin
        check("spurious_word", bus.out_valid_o, 0);
      end else begin
        e = exp_q.pop_front();
        check("word", o, e);
      end
    end
    prev_stall = bus.out_valid_o && !bus.out_ready_i;
    prev_out   = o;
    in_hs = bus.in_valid_i && bus.in_ready_o;
    if (in_hs) begin
      if (!m_active) check("beat_while_idle", bus.in_ready_o, 0);
      else           model_beat(bus.in_data_i, bus.in_last_i);
    end
    if (bus.start_i && !m_active && bus.sew_i != 2'd3) begin
      m_active = 1;
      m_sew    = bus.sew_i;
      m_sext   = bus.sext_i;
      cur_w    = '0;
      cur_n    = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (rand_mode) bus.out_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic do_start(input logic [1:0] sew, input logic sext);
    bus.start_i = 1'b1;
    bus.sew_i   = sew;
    bus.sext_i  = sext;
    tick();
    bus.start_i = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] data, input logic last);
    int t;
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = data;
    bus.in_last_i  = last;
    t = 0;
    do begin
      tick();
      t++;
    end while (!in_hs && t < 200);
    if (!in_hs) check("beat_timeout", bus.in_ready_o, 1);
    bus.in_valid_i = 1'b0;
    bus.in_last_i  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nb;
    int t;
    bus.start_i = 0; bus.sew_i = 0; bus.sext_i = 0; bus.in_valid_i = 0;
    bus.in_data_i = '0; bus.in_last_i = 0; bus.out_ready_i = 1;
    cur_w = '0; cur_n = 0; m_active = 0; prev_out = '0;

    repeat (3) tick();
    check("rst_out_valid", bus.out_valid_o, 0);
    check("rst_out_data", bus.out_data_o, 0);
    check("rst_lane_en", bus.out_lane_en_o, 0);
    check("rst_out_last", bus.out_last_o, 0);
    check("rst_cfg_err", bus.cfg_err_o, 0);
    check("rst_in_ready", bus.in_ready_o, 0);
    n_rst = 1'b1;
    tick();

    // sew=8b, zero-extend
    do_start(2'd0, 1'b0);
    send_beat(32'h83027F01, 1'b1);
    check("b8z_valid", bus.out_valid_o, 1);
    check("b8z_data", bus.out_data_o, 128'h00000083_00000002_0000007F_00000001);
    check("b8z_en", bus.out_lane_en_o, 4'b1111);
    check("b8z_last", bus.out_last_o, 1);
    check("b8z_idle", bus.in_ready_o, 0);

    // sew=8b, sign-extend
    do_start(2'd0, 1'b1);
    send_beat(32'h83027F01, 1'b1);
    check("b8s_data", bus.out_data_o, 128'hFFFFFF83_00000002_0000007F_00000001);

    // sew=16b, two beats
    do_start(2'd1, 1'b1);
    send_beat(32'h11112222, 1'b0);
    check("b16_no_early", bus.out_valid_o, 0);
    send_beat(32'h80004444, 1'b1);
    check("b16_valid", bus.out_valid_o, 1);
    check("b16_data", bus.out_data_o, 128'hFFFF8000_00004444_00001111_00002222);
    check("b16_en", bus.out_lane_en_o, 4'b1111);

    // sew=32b, short transfer
    do_start(2'd2, 1'b0);
    send_beat(32'hA, 1'b0);
    send_beat(32'hB, 1'b0);
    send_beat(32'hC, 1'b1);
    check("b32_data", bus.out_data_o, 128'h00000000_0000000C_0000000B_0000000A);
    check("b32_en", bus.out_lane_en_o, 4'b0111);
    check("b32_last", bus.out_last_o, 1);
    check("b32_idle", bus.in_ready_o, 0);

    // backpressure
    tick();
    bus.out_ready_i = 1'b0;
    do_start(2'd0, 1'b0);
    send_beat(32'h04030201, 1'b0);
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = 32'hF0E0D0C0;
    bus.in_last_i  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", bus.out_valid_o, 1);
      check("bp_hold", bus.out_data_o, 128'h00000004_00000003_00000002_00000001);
      check("bp_in_ready", bus.in_ready_o, 0);
      tick();
    end
    bus.out_ready_i = 1'b1;
    send_beat(32'hF0E0D0C0, 1'b1);
    check("bp2_valid", bus.out_valid_o, 1);
    check("bp2_data", bus.out_data_o, 128'h000000F0_000000E0_000000D0_000000C0);
    check("bp2_last", bus.out_last_o, 1);
    tick();

    // reserved sew
    do_start(2'd3, 1'b0);
    check("cfg_err_pulse", bus.cfg_err_o, 1);
    check("cfg_err_idle", bus.in_ready_o, 0);
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = 32'h12345678;
    tick();
    check("cfg_err_clear", bus.cfg_err_o, 0);
    check("cfg_err_refuse", bus.in_ready_o, 0);
    tick();
    check("cfg_err_refuse2", bus.in_ready_o, 0);
    bus.in_valid_i = 1'b0;

    // reset mid-transfer
    do_start(2'd1, 1'b0);
    send_beat(32'hDEADBEEF, 1'b0);
    n_rst = 1'b0;
    tick();
    check("mid_rst_valid", bus.out_valid_o, 0);
    check("mid_rst_data", bus.out_data_o, 0);
    check("mid_rst_en", bus.out_lane_en_o, 0);
    check("mid_rst_ready", bus.in_ready_o, 0);
    n_rst = 1'b1;
    tick();
    do_start(2'd1, 1'b0);
    send_beat(32'h00010002, 1'b0);
    send_beat(32'h00030004, 1'b1);
    check("post_rst_data", bus.out_data_o, 128'h00000003_00000004_00000001_00000002);
    check("post_rst_en", bus.out_lane_en_o, 4'b1111);

    // randomized transfers with random backpressure and gaps
    rand_mode = 1;
    for (int k = 0; k < 40; k++) begin
      do_start(2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      nb = $urandom_range(1, 6);
      for (int b = 0; b < nb; b++) begin
        repeat ($urandom_range(0, 2)) tick();
        send_beat($urandom, (b == nb - 1));
      end
    end
    rand_mode = 0;
    bus.out_ready_i = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      tick();
      t++;
    end
    check("drain", exp_q.size(), 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
